// File: rtl/div_burst_ctrl_if.sv
// Config channel for div_burst_ctrl: valid/ready offer of half-period and burst length.
// The master drives the offer; the slave returns ready while it has room to take it.
interface div_burst_ctrl_if #(
  parameter int CNT_W = 32,
  parameter int BST_W = 16
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_half;
  logic [BST_W-1:0] cfg_cycles;

  modport master (
    output cfg_valid,
    output cfg_half,
    output cfg_cycles,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_half,
    input  cfg_cycles,
    output cfg_ready
  );
endinterface

// File: rtl/div_burst_ctrl.sv
// Divided-clock burst sequencer: 50% duty clk_out of period 2*half, burst of N periods or free-run.
// Outputs registered, start acts one cycle later; config stalls (ready low) while a mid-run update is pending.
module div_burst_ctrl #(
  parameter int CNT_W    = 32,
  parameter int BST_W    = 16,
  parameter int DEF_HALF = 500
) (
  input  logic             clk_in,
  input  logic             rst,
  div_burst_ctrl_if.slave  cfg,
  input  logic             start,
  input  logic             stop,
  output logic             clk_out,
  output logic             tick_out,
  output logic             busy,
  output logic             done,
  output logic [BST_W-1:0] cycles_left
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(DEF_HALF);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [BST_W-1:0] BST_ONE  = BST_W'(1);

  state_e           state_q, state_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [BST_W-1:0] left_q, left_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [BST_W-1:0] cycles_q, cycles_d;
  logic [CNT_W-1:0] sh_half_q, sh_half_d;
  logic [BST_W-1:0] sh_cyc_q, sh_cyc_d;
  logic             pend_q, pend_d;
  logic             cyc_pend_q, cyc_pend_d;

  logic             xfer;
  logic [CNT_W-1:0] cfg_half_c;
  logic             phase_end;
  logic             last_period;

  assign cfg.cfg_ready = !pend_q;
  assign xfer          = cfg.cfg_valid && !pend_q;
  assign cfg_half_c    = (cfg.cfg_half == '0) ? CNT_ONE : cfg.cfg_half;
  assign phase_end     = (count_q >= half_q);
  assign last_period   = (cycles_q != '0) && (left_q == BST_ONE);

  assign clk_out     = clk_out_q;
  assign tick_out    = tick_q;
  assign done        = done_q;
  assign cycles_left = left_q;
  assign busy        = (state_q != S_IDLE);

  always_comb begin
    state_d    = state_q;
    clk_out_d  = clk_out_q;
    tick_d     = 1'b0;
    done_d     = 1'b0;
    count_d    = count_q;
    left_d     = left_q;
    half_d     = half_q;
    cycles_d   = cycles_q;
    sh_half_d  = sh_half_q;
    sh_cyc_d   = sh_cyc_q;
    pend_d     = pend_q;
    cyc_pend_d = cyc_pend_q;

    case (state_q)
      S_IDLE: begin
        clk_out_d = 1'b0;
        count_d   = CNT_ONE;
        if (xfer) begin
          half_d   = cfg_half_c;
          cycles_d = cfg.cfg_cycles;
        end
        if (start && !stop) begin
          state_d   = S_RUN;
          clk_out_d = 1'b1;
          tick_d    = 1'b1;
          left_d    = xfer ? cfg.cfg_cycles : cycles_q;
        end
      end

      S_RUN, S_DRAIN: begin
        if (xfer) begin
          sh_half_d  = cfg_half_c;
          sh_cyc_d   = cfg.cfg_cycles;
          pend_d     = 1'b1;
          cyc_pend_d = 1'b1;
        end
        count_d = count_q + CNT_ONE;
        if (state_q == S_RUN && stop) begin
          state_d = S_DRAIN;
        end
        if (phase_end) begin
          count_d = CNT_ONE;
          if (clk_out_q) begin
            clk_out_d = 1'b0;
          end else if (state_q == S_DRAIN || stop || last_period) begin
            // Sequence ends on this boundary; any outstanding update lands now
            // so the idle block accepts fresh config immediately.
            state_d    = S_IDLE;
            clk_out_d  = 1'b0;
            done_d     = 1'b1;
            left_d     = '0;
            pend_d     = 1'b0;
            cyc_pend_d = 1'b0;
            if (xfer) begin
              half_d   = cfg_half_c;
              cycles_d = cfg.cfg_cycles;
            end else begin
              if (pend_q)     half_d   = sh_half_q;
              if (cyc_pend_q) cycles_d = sh_cyc_q;
            end
          end else begin
            clk_out_d = 1'b1;
            tick_d    = 1'b1;
            if (cycles_q != '0) left_d = left_q - BST_ONE;
            // A half offered on the boundary itself goes straight into the new period.
            if (xfer) begin
              half_d = cfg_half_c;
              pend_d = 1'b0;
            end else if (pend_q) begin
              half_d = sh_half_q;
              pend_d = 1'b0;
            end
          end
        end
      end

      default: begin
        state_d   = S_IDLE;
        clk_out_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q    <= S_IDLE;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
      done_q     <= 1'b0;
      count_q    <= CNT_ONE;
      left_q     <= '0;
      half_q     <= HALF_RST;
      cycles_q   <= '0;
      sh_half_q  <= HALF_RST;
      sh_cyc_q   <= '0;
      pend_q     <= 1'b0;
      cyc_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
      done_q     <= done_d;
      count_q    <= count_d;
      left_q     <= left_d;
      half_q     <= half_d;
      cycles_q   <= cycles_d;
      sh_half_q  <= sh_half_d;
      sh_cyc_q   <= sh_cyc_d;
      pend_q     <= pend_d;
      cyc_pend_q <= cyc_pend_d;
    end
  end

endmodule

// File: tb/tb_div_burst_ctrl.sv
// Bench for div_burst_ctrl: directed scenarios plus random bursts against a period-level trace model.
module tb_div_burst_ctrl;
  localparam int CNT_W = 32;
  localparam int BST_W = 16;

  logic             clk_in = 1'b0;
  logic             rst;
  logic             start;
  logic             stop;
  logic             clk_out;
  logic             tick_out;
  logic             busy;
  logic             done;
  logic [BST_W-1:0] cycles_left;

  div_burst_ctrl_if #(.CNT_W(CNT_W), .BST_W(BST_W)) cfg ();

  div_burst_ctrl #(.CNT_W(CNT_W), .BST_W(BST_W), .DEF_HALF(500)) dut (
    .clk_in      (clk_in),
    .rst         (rst),
    .cfg         (cfg.slave),
    .start       (start),
    .stop        (stop),
    .clk_out     (clk_out),
    .tick_out    (tick_out),
    .busy        (busy),
    .done        (done),
    .cycles_left (cycles_left)
  );

  always #5 clk_in = ~clk_in;

  int checks   = 0;
  int failures = 0;
  int cur_cyc  = 0;

  // Expected per-cycle trace, entry k describes cycle k+1 after start.
  int q_clk[$];
  int q_tick[$];
  int q_busy[$];
  int q_done[$];
  int q_left[$];
  int q_rdy[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, cur_cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic push_cyc(input int c, input int t, input int b, input int d, input int l, input int r);
    q_clk.push_back(c);
    q_tick.push_back(t);
    q_busy.push_back(b);
    q_done.push_back(d);
    q_left.push_back(l);
    q_rdy.push_back(r);
  endtask

  // Period-by-period trace: h high then h low per period, tick at period start,
  // ends after n periods or after the period containing stop cycle s.
  // An offer at cycle c holds ready low until its period ends; later periods use h2.
  task automatic build(input int h1, input int n, input int c, input int h2, input int s);
    int t, h, p, st, en;
    bit fin;
    q_clk.delete(); q_tick.delete(); q_busy.delete();
    q_done.delete(); q_left.delete(); q_rdy.delete();
    t = 1; h = h1; p = 0; fin = 1'b0;
    while (!fin) begin
      st = t;
      for (int i = 0; i < 2 * h; i++) begin
        push_cyc((i < h) ? 1 : 0, (i == 0) ? 1 : 0, 1, 0, (n == 0) ? 0 : n - p, 1);
        t++;
      end
      en = t - 1;
      if (c != 0 && c >= st && c <= en) begin
        for (int k = c + 1; k <= en; k++) q_rdy[k-1] = 0;
        h = h2;
      end
      p++;
      if ((n != 0 && p == n) || (s != 0 && s >= st && s <= en) || t > 5000) fin = 1'b1;
    end
    push_cyc(0, 0, 0, 1, 0, 1);
    push_cyc(0, 0, 0, 0, 0, 1);
  endtask

  // Start in cycle 0 (optionally with config), then walk the trace cycle by cycle.
  task automatic run_seq(input int drv_half, input int mh, input int n, input int c,
                         input int h2, input int s, input int sp, input bit use_cfg);
    build(mh, n, c, h2, s);
    cfg.cfg_valid  = use_cfg;
    cfg.cfg_half   = CNT_W'(drv_half);
    cfg.cfg_cycles = BST_W'(n);
    start          = 1'b1;
    step();
    cfg.cfg_valid = 1'b0;
    start         = 1'b0;
    for (int k = 0; k < q_clk.size(); k++) begin
      cur_cyc = k + 1;
      chk("clk_out",     64'(clk_out),       64'(q_clk[k]));
      chk("tick_out",    64'(tick_out),      64'(q_tick[k]));
      chk("busy",        64'(busy),          64'(q_busy[k]));
      chk("done",        64'(done),          64'(q_done[k]));
      chk("cycles_left", 64'(cycles_left),   64'(q_left[k]));
      chk("cfg_ready",   64'(cfg.cfg_ready), 64'(q_rdy[k]));
      stop  = (k + 1 == s);
      start = (k + 1 == sp);
      if (k + 1 == c) begin
        cfg.cfg_valid  = 1'b1;
        cfg.cfg_half   = CNT_W'(h2);
        cfg.cfg_cycles = BST_W'($urandom_range(0, 3));
      end else begin
        cfg.cfg_valid = 1'b0;
      end
      step();
    end
    stop          = 1'b0;
    start         = 1'b0;
    cfg.cfg_valid = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_clk"},   64'(clk_out),       64'd0);
    chk({tag, "_tick"},  64'(tick_out),      64'd0);
    chk({tag, "_busy"},  64'(busy),          64'd0);
    chk({tag, "_done"},  64'(done),          64'd0);
    chk({tag, "_left"},  64'(cycles_left),   64'd0);
    chk({tag, "_ready"}, 64'(cfg.cfg_ready), 64'd1);
  endtask

  initial begin
    int h, n, s, c, h2, sp;
    rst            = 1'b1;
    start          = 1'b0;
    stop           = 1'b0;
    cfg.cfg_valid  = 1'b0;
    cfg.cfg_half   = '0;
    cfg.cfg_cycles = '0;
    step();
    step();
    chk_idle("reset");
    rst = 1'b0;
    step();

    // Burst of 2 periods, half 3: done lands in cycle 13.
    run_seq(3, 3, 2, 0, 0, 0, 0, 1'b1);
    // Free-run half 2, stop during the high phase of the first period.
    run_seq(2, 2, 0, 0, 0, 2, 0, 1'b1);
    // Mid-run reconfig 4 -> 2, plus an ignored start pulse in RUN.
    run_seq(4, 4, 0, 3, 2, 20, 5, 1'b1);
    // Zero half coerced to one.
    run_seq(0, 1, 1, 0, 0, 0, 0, 1'b1);

    // start and stop together in IDLE: stop wins.
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cur_cyc = i + 1;
      chk_idle("start_stop");
      step();
    end

    // Reset in the middle of a burst with a pending update.
    cfg.cfg_valid  = 1'b1;
    cfg.cfg_half   = CNT_W'(4);
    cfg.cfg_cycles = BST_W'(3);
    start          = 1'b1;
    step();
    start          = 1'b0;
    cfg.cfg_half   = CNT_W'(7);
    cfg.cfg_cycles = BST_W'(1);
    step();
    cfg.cfg_valid = 1'b0;
    step();
    cur_cyc = 3;
    chk("pend_ready", 64'(cfg.cfg_ready), 64'd0);
    chk("pend_busy",  64'(busy),          64'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    cur_cyc = 0;
    chk_idle("mid_reset");
    // No new config: default half of 500, free-run, stop early.
    run_seq(0, 500, 0, 0, 0, 5, 0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      h  = $urandom_range(1, 5);
      n  = $urandom_range(0, 3);
      h2 = $urandom_range(1, 5);
      c  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 2 * h) : 0;
      sp = $urandom_range(2, 2 * h);
      if (n == 0) s = $urandom_range(1, 6 * h);
      else        s = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 2 * h * n) : 0;
      run_seq(h, h, n, c, h2, s, sp, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
